// File: rtl/controlador_de_acesso_pkg.sv
// Shared definitions for the access session controller: state encodings,
// code width and the "no user / no function" code constants.
package controlador_de_acesso_pkg;

    localparam int CODE_W = 3;

    typedef logic [CODE_W-1:0] codigo_t;

    localparam codigo_t USER_NONE = 3'b000;
    localparam codigo_t FUNC_NONE = 3'b000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACTIVE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_GRANT  = 3'd3;
    localparam logic [2:0] ST_DENY   = 3'd4;
    localparam logic [2:0] ST_LOCKED = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_CHECK  = ST_CHECK,
        S_GRANT  = ST_GRANT,
        S_DENY   = ST_DENY,
        S_LOCKED = ST_LOCKED
    } estado_t;

endpackage

// File: rtl/controlador_de_acesso_if.sv
// Permission-check bus between the session controller (master) and the
// combinational permission verifier (slave).
interface controlador_de_acesso_if;
    import controlador_de_acesso_pkg::*;

    codigo_t chk_user;
    codigo_t chk_func;
    codigo_t chk_result;

    modport master (
        output chk_user,
        output chk_func,
        input  chk_result
    );

    modport slave (
        input  chk_user,
        input  chk_func,
        output chk_result
    );

endinterface

// File: rtl/controlador_de_acesso_contador.sv
// contador_regressivo: loadable down-counter that stops at zero and flags it.
module contador_regressivo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/controlador_de_acesso.sv
// Session controller: login, per-request permission check, timed grant window,
// inactivity timeout and lockout after repeated denials.
module controlador_de_acesso
    import controlador_de_acesso_pkg::*;
#(
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_DENIALS    = 3,
    parameter int LOCK_CYCLES    = 64
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    login_valid,
    input  codigo_t login_user,
    input  logic    func_valid,
    input  codigo_t func_req,
    input  logic    logout,
    controlador_de_acesso_if.master chk,
    output logic    session_active,
    output codigo_t cur_user,
    output logic    busy,
    output logic    func_grant_valid,
    output codigo_t func_grant,
    output logic    func_denied,
    output logic    locked
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int DEN_W  = $clog2(MAX_DENIALS + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [DEN_W-1:0]  DEN_MAX   = DEN_W'(MAX_DENIALS);

    estado_t state, state_nxt;

    logic hold_load, hold_en, hold_zero;
    logic idle_load, idle_en, idle_zero;
    logic lock_load, lock_en, lock_zero;

    logic login_acc, func_acc, grant_acc, deny_acc;

    logic [DEN_W-1:0] deny_cnt;

    contador_regressivo #(.W(HOLD_W)) u_hold (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .en       (hold_en),
        .zero     (hold_zero)
    );

    contador_regressivo #(.W(IDLE_W)) u_idle (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (idle_load),
        .load_val (IDLE_LOAD),
        .en       (idle_en),
        .zero     (idle_zero)
    );

    contador_regressivo #(.W(LOCK_W)) u_lock (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (lock_load),
        .load_val (LOCK_LOAD),
        .en       (lock_en),
        .zero     (lock_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each timed state loads its counter with (length-1) on entry and leaves
    // once the counter has run down to zero.
    always_comb begin
        state_nxt        = state;
        hold_load        = 1'b0;
        hold_en          = 1'b0;
        idle_load        = 1'b0;
        idle_en          = 1'b0;
        lock_load        = 1'b0;
        lock_en          = 1'b0;
        login_acc        = 1'b0;
        func_acc         = 1'b0;
        grant_acc        = 1'b0;
        deny_acc         = 1'b0;
        session_active   = 1'b0;
        busy             = 1'b0;
        func_grant_valid = 1'b0;
        func_denied      = 1'b0;
        locked           = 1'b0;

        case (state)
            S_IDLE: begin
                if (login_valid && (login_user != USER_NONE)) begin
                    state_nxt = S_ACTIVE;
                    login_acc = 1'b1;
                    idle_load = 1'b1;
                end
            end
            S_ACTIVE: begin
                session_active = 1'b1;
                if (logout) begin
                    state_nxt = S_IDLE;
                end else if (func_valid && (func_req != FUNC_NONE)) begin
                    state_nxt = S_CHECK;
                    func_acc  = 1'b1;
                end else if (idle_zero) begin
                    state_nxt = S_IDLE;
                end else begin
                    idle_en = 1'b1;
                end
            end
            S_CHECK: begin
                session_active = 1'b1;
                busy           = 1'b1;
                if (logout) begin
                    state_nxt = S_IDLE;
                end else if (chk.chk_result != FUNC_NONE) begin
                    state_nxt = S_GRANT;
                    grant_acc = 1'b1;
                    hold_load = 1'b1;
                end else begin
                    state_nxt = S_DENY;
                    deny_acc  = 1'b1;
                end
            end
            S_GRANT: begin
                session_active   = 1'b1;
                busy             = 1'b1;
                func_grant_valid = 1'b1;
                if (logout) begin
                    state_nxt = S_IDLE;
                end else if (hold_zero) begin
                    state_nxt = S_ACTIVE;
                    idle_load = 1'b1;
                end else begin
                    hold_en = 1'b1;
                end
            end
            S_DENY: begin
                session_active = 1'b1;
                busy           = 1'b1;
                func_denied    = 1'b1;
                if (deny_cnt == DEN_MAX) begin
                    state_nxt = S_LOCKED;
                    lock_load = 1'b1;
                end else begin
                    state_nxt = S_ACTIVE;
                    idle_load = 1'b1;
                end
            end
            S_LOCKED: begin
                busy   = 1'b1;
                locked = 1'b1;
                if (lock_zero) begin
                    state_nxt = S_IDLE;
                end else begin
                    lock_en = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Session registers: cleared whenever the session ends (logout, timeout, lockout).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_user     <= USER_NONE;
            chk.chk_user <= USER_NONE;
            chk.chk_func <= FUNC_NONE;
            func_grant   <= FUNC_NONE;
            deny_cnt     <= '0;
        end else begin
            if ((state_nxt == S_IDLE) || (state_nxt == S_LOCKED)) begin
                cur_user     <= USER_NONE;
                chk.chk_user <= USER_NONE;
                chk.chk_func <= FUNC_NONE;
            end else if (login_acc) begin
                cur_user     <= login_user;
                chk.chk_user <= login_user;
            end else if (func_acc) begin
                chk.chk_func <= func_req;
            end

            if (grant_acc) begin
                func_grant <= chk.chk_result;
            end else if (state_nxt != S_GRANT) begin
                func_grant <= FUNC_NONE;
            end

            if (login_acc || grant_acc) begin
                deny_cnt <= '0;
            end else if (deny_acc && (deny_cnt != DEN_MAX)) begin
                deny_cnt <= deny_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_controlador_de_acesso.sv
// Directed bench for controlador_de_acesso with a cycle-level reference model
// of the session rules and a permission table standing in for the verifier.
module tb_controlador_de_acesso;

    localparam int HOLD    = 8;
    localparam int TIMEOUT = 1000;
    localparam int MAXDEN  = 3;
    localparam int LOCKLEN = 64;

    localparam int OFF     = 0;
    localparam int SESSION = 1;
    localparam int PENDING = 2;
    localparam int GRANTED = 3;
    localparam int REFUSED = 4;
    localparam int LOCKOUT = 5;

    logic       clk;
    logic       reset_n;
    logic       login_valid;
    logic [2:0] login_user;
    logic       func_valid;
    logic [2:0] func_req;
    logic       logout;
    logic       session_active;
    logic [2:0] cur_user;
    logic       busy;
    logic       func_grant_valid;
    logic [2:0] func_grant;
    logic       func_denied;
    logic       locked;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 0;

    controlador_de_acesso_if chk_if ();

    // User 6 may only use function 1; every other user may use anything.
    function automatic logic [2:0] verif(input logic [2:0] u, input logic [2:0] f);
        if (f == 3'd0) return 3'd0;
        if (u == 3'd6 && f != 3'd1) return 3'd0;
        return f;
    endfunction

    assign chk_if.chk_result = verif(chk_if.chk_user, chk_if.chk_func);

    controlador_de_acesso #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_DENIALS    (MAXDEN),
        .LOCK_CYCLES    (LOCKLEN)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .login_valid      (login_valid),
        .login_user       (login_user),
        .func_valid       (func_valid),
        .func_req         (func_req),
        .logout           (logout),
        .chk              (chk_if),
        .session_active   (session_active),
        .cur_user         (cur_user),
        .busy             (busy),
        .func_grant_valid (func_grant_valid),
        .func_grant       (func_grant),
        .func_denied      (func_denied),
        .locked           (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: session mode plus up-counting ages, advanced once per clock.
    int         m_mode  = OFF;
    logic [2:0] m_user  = 3'd0;
    logic [2:0] m_func  = 3'd0;
    logic [2:0] m_grant = 3'd0;
    int         m_idle  = 0;
    int         m_age   = 0;
    int         m_lock  = 0;
    int         m_den   = 0;

    task automatic end_session();
        m_mode  = OFF;
        m_user  = 3'd0;
        m_func  = 3'd0;
        m_grant = 3'd0;
        m_idle  = 0;
    endtask

    task automatic model_step();
        logic [2:0] r;
        if (!reset_n) begin
            end_session();
            m_age  = 0;
            m_lock = 0;
            m_den  = 0;
            return;
        end
        case (m_mode)
            OFF: begin
                if (login_valid && login_user != 3'd0) begin
                    m_mode = SESSION;
                    m_user = login_user;
                    m_idle = 0;
                    m_den  = 0;
                end
            end
            SESSION: begin
                if (logout) end_session();
                else if (func_valid && func_req != 3'd0) begin
                    m_mode = PENDING;
                    m_func = func_req;
                end else begin
                    m_idle++;
                    if (m_idle >= TIMEOUT) end_session();
                end
            end
            PENDING: begin
                if (logout) end_session();
                else begin
                    r = verif(m_user, m_func);
                    if (r != 3'd0) begin
                        m_mode  = GRANTED;
                        m_grant = r;
                        m_age   = 0;
                        m_den   = 0;
                    end else begin
                        m_mode = REFUSED;
                        if (m_den < MAXDEN) m_den++;
                    end
                end
            end
            GRANTED: begin
                if (logout) end_session();
                else begin
                    m_age++;
                    if (m_age >= HOLD) begin
                        m_mode  = SESSION;
                        m_grant = 3'd0;
                        m_idle  = 0;
                    end
                end
            end
            REFUSED: begin
                if (m_den == MAXDEN) begin
                    m_mode = LOCKOUT;
                    m_lock = 0;
                    m_user = 3'd0;
                    m_func = 3'd0;
                end else begin
                    m_mode = SESSION;
                    m_idle = 0;
                end
            end
            default: begin
                m_lock++;
                if (m_lock >= LOCKLEN) end_session();
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            check("session_active", session_active,
                  (m_mode == SESSION || m_mode == PENDING || m_mode == GRANTED || m_mode == REFUSED) ? 1 : 0);
            check("busy", busy,
                  (m_mode == PENDING || m_mode == GRANTED || m_mode == REFUSED || m_mode == LOCKOUT) ? 1 : 0);
            check("func_grant_valid", func_grant_valid, (m_mode == GRANTED) ? 1 : 0);
            check("func_grant", func_grant, m_grant);
            check("func_denied", func_denied, (m_mode == REFUSED) ? 1 : 0);
            check("locked", locked, (m_mode == LOCKOUT) ? 1 : 0);
            check("cur_user", cur_user, m_user);
            check("chk_user", chk_if.chk_user, m_user);
            check("chk_func", chk_if.chk_func, m_func);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_login(input logic [2:0] u);
        login_valid = 1'b1;
        login_user  = u;
        tick();
        login_valid = 1'b0;
        login_user  = 3'd0;
    endtask

    task automatic do_req(input logic [2:0] f);
        func_valid = 1'b1;
        func_req   = f;
        tick();
        func_valid = 1'b0;
        func_req   = 3'd0;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_session_active"}, session_active, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_valid"}, func_grant_valid, 0);
        check({tag, "_func_grant"}, func_grant, 0);
        check({tag, "_denied"}, func_denied, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_cur_user"}, cur_user, 0);
        check({tag, "_chk_user"}, chk_if.chk_user, 0);
        check({tag, "_chk_func"}, chk_if.chk_func, 0);
    endtask

    initial begin
        reset_n     = 1'b1;
        login_valid = 1'b0;
        login_user  = 3'd0;
        func_valid  = 1'b0;
        func_req    = 3'd0;
        logout      = 1'b0;
        #1;
        reset_n = 1'b0;
        cmp_on  = 1'b1;
        repeat (3) tick();
        all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Grant path: user 6, function 1
        do_login(3'd6);
        check("login_session_active", session_active, 1);
        check("login_cur_user", cur_user, 6);
        do_req(3'd1);
        check("check_busy", busy, 1);
        check("check_chk_func", chk_if.chk_func, 1);
        tick();
        check("grant_valid_first", func_grant_valid, 1);
        check("grant_value", func_grant, 1);
        repeat (HOLD - 1) tick();
        check("grant_valid_last", func_grant_valid, 1);
        tick();
        check("after_grant_valid", func_grant_valid, 0);
        check("after_grant_session", session_active, 1);
        check("after_grant_busy", busy, 0);

        // Three denials for user 6 on function 2 lead to lockout
        for (int i = 0; i < MAXDEN; i++) begin
            do_req(3'd2);
            tick();
            check("deny_pulse", func_denied, 1);
            tick();
            check("deny_pulse_end", func_denied, 0);
            if (i < MAXDEN - 1) check("deny_back_active", session_active, 1);
        end
        check("lock_entered", locked, 1);
        check("lock_cur_user", cur_user, 0);
        repeat (LOCKLEN - 1) tick();
        check("lock_last_cycle", locked, 1);
        tick();
        check("lock_released", locked, 0);
        check("lock_to_idle", session_active, 0);

        // Logout in the middle of a grant window
        do_login(3'd5);
        do_req(3'd7);
        tick();
        check("grant7_value", func_grant, 7);
        tick();
        logout = 1'b1;
        tick();
        logout = 1'b0;
        check("logout_grant_valid", func_grant_valid, 0);
        check("logout_func_grant", func_grant, 0);
        check("logout_cur_user", cur_user, 0);

        // Inactivity timeout
        do_login(3'd3);
        repeat (TIMEOUT - 1) tick();
        check("timeout_not_yet", session_active, 1);
        tick();
        check("timeout_logged_out", session_active, 0);
        do_req(3'd1);
        tick();
        check("post_timeout_no_grant", func_grant_valid, 0);
        check("post_timeout_no_deny", func_denied, 0);
        check("post_timeout_busy", busy, 0);

        // logout wins over a same-cycle request
        do_login(3'd6);
        logout     = 1'b1;
        func_valid = 1'b1;
        func_req   = 3'd3;
        tick();
        logout     = 1'b0;
        func_valid = 1'b0;
        func_req   = 3'd0;
        check("prio_session", session_active, 0);
        check("prio_chk_func", chk_if.chk_func, 0);
        tick();
        check("prio_no_grant", func_grant_valid, 0);
        check("prio_no_deny", func_denied, 0);

        // Asynchronous reset during CHECK
        do_login(3'd2);
        do_req(3'd4);
        check("pre_reset_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        all_zero("rst_check");
        tick();
        reset_n = 1'b1;
        tick();

        // Asynchronous reset during LOCKED
        do_login(3'd6);
        for (int i = 0; i < MAXDEN; i++) begin
            do_req(3'd2);
            tick();
            tick();
        end
        repeat (5) tick();
        check("pre_reset_locked", locked, 1);
        #2;
        reset_n = 1'b0;
        #1;
        all_zero("rst_locked");
        tick();
        reset_n = 1'b1;
        tick();

        // Normal operation after reset
        do_login(3'd1);
        do_req(3'd4);
        tick();
        check("final_grant_valid", func_grant_valid, 1);
        check("final_grant", func_grant, 4);
        repeat (HOLD + 2) tick();

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
